// File: rtl/uart_tx_if.sv
// Byte handshake between the upstream encoder and the UART transmitter.
// The encoder (master) offers uin_data/uin_valid, and the transmitter (slave) returns uin_ready.
interface uart_tx_if;
    logic [7:0] uin_data;
    logic       uin_valid;
    logic       uin_ready;

    modport master (output uin_data, output uin_valid, input uin_ready);
    modport slave  (input uin_data, input uin_valid, output uin_ready);
endinterface

// File: rtl/uart_tx.sv
// 8N1 UART transmitter fed from a 4-entry byte FIFO.
// Overflow is sticky and clears only on reset.
module uart_tx #(
    parameter int unsigned CLKS_PER_BIT = 434
) (
    input  logic     clk,
    input  logic     n_rst,
    uart_tx_if.slave uin,
    output logic     tx,
    output logic     tx_busy,
    output logic     ovf
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] START = 2'd1;
    localparam logic [1:0] DATA  = 2'd2;
    localparam logic [1:0] STOP  = 2'd3;

    localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);

    logic [1:0]  state_q, state_d;
    logic [2:0]  count_q, count_d;
    logic [1:0]  rptr_q, rptr_d;
    logic [1:0]  wptr_q, wptr_d;
    logic [7:0]  mem_q [4];
    logic [7:0]  shift_q, shift_d;
    logic [15:0] baud_q, baud_d;
    logic [2:0]  bit_idx_q, bit_idx_d;
    logic        ovf_q, ovf_d;

    logic ready;
    logic push;
    logic pop;
    logic baud_end;

    // Readiness depends only on the registered count, so a same-edge pop never frees a slot.
    assign ready    = (count_q < 3'd4);
    assign push     = uin.uin_valid && ready;
    assign pop      = (state_q == IDLE) && (count_q != 3'd0);
    assign baud_end = (baud_q == BAUD_LAST);

    always_comb begin
        count_d = count_q;
        rptr_d  = rptr_q;
        wptr_d  = wptr_q;
        ovf_d   = ovf_q | (uin.uin_valid & ~ready);
        case ({push, pop})
            2'b10:   count_d = count_q + 3'd1;
            2'b01:   count_d = count_q - 3'd1;
            default: count_d = count_q;
        endcase
        if (push) wptr_d = wptr_q + 2'd1;
        if (pop)  rptr_d = rptr_q + 2'd1;
    end

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        baud_d    = baud_q;
        bit_idx_d = bit_idx_q;
        case (state_q)
            IDLE: begin
                if (pop) begin
                    state_d = START;
                    shift_d = mem_q[rptr_q];
                    baud_d  = 16'd0;
                end
            end
            START: begin
                if (baud_end) begin
                    state_d   = DATA;
                    baud_d    = 16'd0;
                    bit_idx_d = 3'd0;
                end else begin
                    baud_d = baud_q + 16'd1;
                end
            end
            DATA: begin
                if (baud_end) begin
                    baud_d    = 16'd0;
                    shift_d   = {1'b0, shift_q[7:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) state_d = STOP;
                end else begin
                    baud_d = baud_q + 16'd1;
                end
            end
            default: begin
                // STOP always returns to IDLE, which guarantees an idle-high cycle between frames.
                if (baud_end) begin
                    state_d = IDLE;
                    baud_d  = 16'd0;
                end else begin
                    baud_d = baud_q + 16'd1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q   <= IDLE;
            count_q   <= 3'd0;
            rptr_q    <= 2'd0;
            wptr_q    <= 2'd0;
            shift_q   <= 8'h00;
            baud_q    <= 16'd0;
            bit_idx_q <= 3'd0;
            ovf_q     <= 1'b0;
            for (int i = 0; i < 4; i++) mem_q[i] <= 8'h00;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            rptr_q    <= rptr_d;
            wptr_q    <= wptr_d;
            shift_q   <= shift_d;
            baud_q    <= baud_d;
            bit_idx_q <= bit_idx_d;
            ovf_q     <= ovf_d;
            if (push) mem_q[wptr_q] <= uin.uin_data;
        end
    end

    always_comb begin
        case (state_q)
            START:   tx = 1'b0;
            DATA:    tx = shift_q[0];
            default: tx = 1'b1;
        endcase
    end

    assign tx_busy       = (state_q != IDLE) || (count_q != 3'd0);
    assign ovf           = ovf_q;
    assign uin.uin_ready = ready;

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx with CLKS_PER_BIT=4.
// It compares the DUT with a queue-based frame model every cycle and decodes the serial line.
module tb_uart_tx;
    localparam int CPB   = 4;
    localparam int FRAME = 10 * CPB;

    logic clk = 1'b0;
    logic n_rst;
    logic tx, tx_busy, ovf;

    always #5 clk = ~clk;

    uart_tx_if u_if ();

    uart_tx #(.CLKS_PER_BIT(CPB)) dut (
        .clk     (clk),
        .n_rst   (n_rst),
        .uin     (u_if),
        .tx      (tx),
        .tx_busy (tx_busy),
        .ovf     (ovf)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: byte queue plus position within the current 40-cycle frame
    logic [7:0] m_q [$];
    logic [7:0] m_cur;
    bit         m_busy;
    int         m_t;
    bit         m_ovf;

    logic       tx_trace [$];
    logic [7:0] dec_bytes [$];
    int         dec_starts [$];

    typedef struct {
        logic [7:0] data;
        logic [9:0] frame;  // frame[0] = start bit, frame[9] = stop bit
    } vec_t;
    vec_t vecs [5];

    task automatic check_bit(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_busy = 0;
        m_t    = 0;
        m_ovf  = 0;
        m_cur  = 8'h00;
    endtask

    task automatic model_edge(input logic v, input logic [7:0] d);
        bit rdy;
        rdy = (m_q.size() < 4);
        if (m_busy) begin
            m_t++;
            if (m_t == FRAME) m_busy = 0;
        end else if (m_q.size() > 0) begin
            m_cur  = m_q.pop_front();
            m_busy = 1;
            m_t    = 0;
        end
        if (v) begin
            if (rdy) m_q.push_back(d);
            else     m_ovf = 1;
        end
    endtask

    function automatic logic model_tx();
        if (!m_busy)           return 1'b1;
        if (m_t < CPB)         return 1'b0;
        if (m_t < 9 * CPB)     return m_cur[(m_t - CPB) / CPB];
        return 1'b1;
    endfunction

    task automatic compare_model();
        check_bit("model_tx", tx, model_tx());
        check_bit("model_tx_busy", tx_busy, m_busy || (m_q.size() > 0));
        check_bit("model_ovf", ovf, m_ovf);
        check_bit("model_uin_ready", u_if.uin_ready, m_q.size() < 4);
    endtask

    task automatic step();
        @(posedge clk);
        if (n_rst) model_edge(u_if.uin_valid, u_if.uin_data);
        #1;
        compare_model();
        tx_trace.push_back(tx);
    endtask

    task automatic apply_reset();
        u_if.uin_valid = 1'b0;
        n_rst = 1'b0;
        #1;
        model_reset();
        check_bit("rst_tx", tx, 1'b1);
        check_bit("rst_tx_busy", tx_busy, 1'b0);
        check_bit("rst_ovf", ovf, 1'b0);
        check_bit("rst_uin_ready", u_if.uin_ready, 1'b1);
        step();
        step();
        n_rst = 1'b1;
        tx_trace.delete();
    endtask

    task automatic push_byte(input logic [7:0] d);
        u_if.uin_valid = 1'b1;
        u_if.uin_data  = d;
        step();
        u_if.uin_valid = 1'b0;
    endtask

    task automatic run_idle(input string name, input int max);
        for (int i = 0; i < max && tx_busy; i++) step();
        check_bit({name, "_drain"}, tx_busy, 1'b0);
    endtask

    // Independent line decoder: find start bits and sample each bit at mid-period
    task automatic decode_trace();
        int i;
        logic [7:0] b;
        dec_bytes.delete();
        dec_starts.delete();
        i = 0;
        while (i + FRAME <= tx_trace.size()) begin
            if (tx_trace[i] == 1'b0) begin
                for (int k = 0; k < 8; k++) b[k] = tx_trace[i + CPB * (k + 1) + CPB / 2];
                check_bit("stop_bit", tx_trace[i + 9 * CPB + CPB / 2], 1'b1);
                dec_bytes.push_back(b);
                dec_starts.push_back(i);
                i += FRAME;
            end else begin
                i++;
            end
        end
    endtask

    task automatic check_decoded(input string name, input logic [7:0] exp [$]);
        decode_trace();
        check_int({name, "_nbytes"}, dec_bytes.size(), exp.size());
        for (int j = 0; j < exp.size() && j < dec_bytes.size(); j++)
            check_int($sformatf("%s_byte%0d", name, j), int'(dec_bytes[j]), int'(exp[j]));
    endtask

    initial begin
        logic [7:0] exp_q [$];
        int thresh;

        vecs[0] = '{8'h41, 10'b1_01000001_0};
        vecs[1] = '{8'h00, 10'b1_00000000_0};
        vecs[2] = '{8'hFF, 10'b1_11111111_0};
        vecs[3] = '{8'hA5, 10'b1_10100101_0};
        vecs[4] = '{8'h30, 10'b1_00110000_0};

        n_rst = 1'b0;
        u_if.uin_valid = 1'b0;
        u_if.uin_data  = 8'h00;
        #1;
        apply_reset();

        // Single frames: exact waveform, 40 cycles, busy falls at frame end
        for (int v = 0; v < 5; v++) begin
            push_byte(vecs[v].data);
            for (int k = 0; k < FRAME; k++) begin
                step();
                check_bit($sformatf("vec%0d_bit%0d", v, k / CPB), tx, vecs[v].frame[k / CPB]);
            end
            check_bit($sformatf("vec%0d_busy_last", v), tx_busy, 1'b1);
            step();
            check_bit($sformatf("vec%0d_busy_end", v), tx_busy, 1'b0);
        end

        // Three consecutive pushes give three frames with one idle cycle between them
        tx_trace.delete();
        u_if.uin_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            u_if.uin_data = 8'h30 + 8'(i);
            step();
        end
        u_if.uin_valid = 1'b0;
        run_idle("seq3", 300);
        exp_q = '{8'h30, 8'h31, 8'h32};
        check_decoded("seq3", exp_q);
        for (int j = 0; j + 1 < dec_starts.size(); j++)
            check_int($sformatf("seq3_gap%0d", j), dec_starts[j + 1] - dec_starts[j], FRAME + 1);
        check_bit("seq3_ovf", ovf, 1'b0);

        // Six back-to-back pushes: the sixth byte overflows
        apply_reset();
        u_if.uin_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            u_if.uin_data = 8'h50 + 8'(i);
            step();
            if (i == 4) check_bit("burst6_ready_full", u_if.uin_ready, 1'b0);
            if (i == 5) check_bit("burst6_ovf_set", ovf, 1'b1);
        end
        u_if.uin_valid = 1'b0;
        run_idle("burst6", 400);
        exp_q = '{8'h50, 8'h51, 8'h52, 8'h53, 8'h54};
        check_decoded("burst6", exp_q);
        check_bit("burst6_ovf_sticky", ovf, 1'b1);

        // Full FIFO and an IDLE pop edge with a same-edge push offer
        apply_reset();
        push_byte(8'hA0);
        step();
        for (int i = 1; i < 5; i++) push_byte(8'hA0 + 8'(i));
        check_bit("full_ready", u_if.uin_ready, 1'b0);
        for (int i = 0; i < 100 && m_busy; i++) step();
        check_bit("full_idle_tx", tx, 1'b1);
        check_bit("full_idle_ovf", ovf, 1'b0);
        u_if.uin_valid = 1'b1;
        u_if.uin_data  = 8'hEE;
        step();
        u_if.uin_valid = 1'b0;
        check_bit("full_pop_ovf", ovf, 1'b1);
        check_bit("full_pop_ready", u_if.uin_ready, 1'b1);
        check_bit("full_pop_tx", tx, 1'b0);
        run_idle("full", 400);
        exp_q = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4};
        check_decoded("full", exp_q);

        // Reset during data bit 3 with two bytes queued
        apply_reset();
        u_if.uin_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            u_if.uin_data = 8'hC0 + 8'(i);
            step();
        end
        u_if.uin_valid = 1'b0;
        for (int i = 0; i < 100 && !(m_busy && m_t == 4 * CPB + 1); i++) step();
        check_bit("midrst_pre_busy", tx_busy, 1'b1);
        n_rst = 1'b0;
        #1;
        model_reset();
        check_bit("midrst_tx", tx, 1'b1);
        check_bit("midrst_busy", tx_busy, 1'b0);
        check_bit("midrst_ready", u_if.uin_ready, 1'b1);
        step();
        n_rst = 1'b1;
        tx_trace.delete();
        for (int i = 0; i < 100; i++) step();
        exp_q = {};
        check_decoded("midrst", exp_q);
        check_bit("midrst_after_busy", tx_busy, 1'b0);

        // Push and pop on the same edge at count=2, then fill across the pointer wrap
        apply_reset();
        push_byte(8'hD0);
        step();
        push_byte(8'hD1);
        push_byte(8'hD2);
        for (int i = 0; i < 100 && m_busy; i++) step();
        push_byte(8'hD3);
        check_bit("pp_ready_cnt2", u_if.uin_ready, 1'b1);
        push_byte(8'hD4);
        check_bit("pp_ready_cnt3", u_if.uin_ready, 1'b1);
        push_byte(8'hD5);
        check_bit("pp_ready_cnt4", u_if.uin_ready, 1'b0);
        run_idle("pp", 400);
        exp_q = '{8'hD0, 8'hD1, 8'hD2, 8'hD3, 8'hD4, 8'hD5};
        check_decoded("pp", exp_q);

        // Randomized traffic with varying offer density
        apply_reset();
        thresh = 1;
        for (int c = 0; c < 3000; c++) begin
            if (c % 200 == 0) thresh = $urandom_range(0, 2) == 0 ? 1 : ($urandom_range(0, 1) ? 4 : 12);
            u_if.uin_valid = ($urandom_range(0, 15) < thresh);
            u_if.uin_data  = 8'($urandom);
            step();
        end
        u_if.uin_valid = 1'b0;
        run_idle("rand", 400);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
